// File: rtl/clock_mode_fsm_pkg.sv
// clock_mode_fsm_pkg: UI state codes and helpers shared by the clock UI controller and its setting stages
package clock_mode_fsm_pkg;
  typedef enum logic [2:0] {
    RUN     = 3'b000,
    SET_HR  = 3'b001,
    SET_MIN = 3'b010,
    AL_HR   = 3'b011,
    AL_MIN  = 3'b100,
    AL_EN   = 3'b101,
    SET_FMT = 3'b110
  } state_e;
  localparam logic [2:0] ILLEGAL = 3'b111;
  function automatic state_e next_mode(input state_e s);
    return (s == SET_FMT) ? RUN : state_e'(s + 3'd1);
  endfunction
  function automatic logic is_field(input state_e s);
    return s inside {SET_HR, SET_MIN, AL_HR, AL_MIN};
  endfunction
endpackage

// File: rtl/clock_mode_fsm_btn_edge.sv
// btn_edge: registered rising-edge detector (clk, reset, btn in; rise out), prev reg resets high so a held button is not a press
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  logic prev_q, prev_d, rise_q, rise_d;
  always_comb begin
    prev_d = btn;
    rise_d = btn & ~prev_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
      rise_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/clock_mode_fsm.sv
// clock_mode_fsm: alarm-clock UI controller (clk, reset, tick_1hz, btn_mode/up/down/set in; state, mode_disp, alarm_en, inc_pulse, dec_pulse out)
module clock_mode_fsm
  import clock_mode_fsm_pkg::*;
#(
  parameter int TIMEOUT_S = 30,
  parameter int TO_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_set,
  output logic [2:0] state,
  output logic       mode_disp,
  output logic       alarm_en,
  output logic       inc_pulse,
  output logic       dec_pulse
);
  logic e_set, e_mode, e_up, e_down, any_e, act_up, act_dn, expire;
  state_e state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic mode_q, mode_d, al_q, al_d, inc_q, inc_d, dec_q, dec_d;
  btn_edge u_set  (.clk(clk), .reset(reset), .btn(btn_set),  .rise(e_set));
  btn_edge u_mode (.clk(clk), .reset(reset), .btn(btn_mode), .rise(e_mode));
  btn_edge u_up   (.clk(clk), .reset(reset), .btn(btn_up),   .rise(e_up));
  btn_edge u_down (.clk(clk), .reset(reset), .btn(btn_down), .rise(e_down));
  assign any_e  = e_set | e_mode | e_up | e_down;
  assign act_up = ~e_set & ~e_mode & e_up;
  assign act_dn = ~e_set & ~e_mode & ~e_up & e_down;
  assign expire = ~any_e && state_q != RUN && tick_1hz && to_q == TO_W'(TIMEOUT_S - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      to_q    <= '0;
      mode_q  <= 1'b0;
      al_q    <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      mode_q  <= mode_d;
      al_q    <= al_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end
  always_comb begin
    state_d = (state_q == state_e'(ILLEGAL) || expire || e_set) ? RUN :
              e_mode ? next_mode(state_q) : state_q;
    to_d    = (state_q == RUN || any_e || state_d != state_q) ? '0 : to_q + TO_W'(tick_1hz);
  end
  always_comb begin
    inc_d  = is_field(state_q) & act_up;
    dec_d  = is_field(state_q) & act_dn;
    al_d   = al_q ^ (state_q == AL_EN && (act_up || act_dn));
    mode_d = mode_q ^ (state_q == SET_FMT && (act_up || act_dn));
  end
  assign state     = state_q;
  assign mode_disp = mode_q;
  assign alarm_en  = al_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
endmodule

// File: tb/tb_clock_mode_fsm.sv
// tb_clock_mode_fsm: directed and randomized checks of clock_mode_fsm against a behavioural model
module tb_clock_mode_fsm;
  localparam int TO = 3;
  logic clk = 0, reset = 1, tick = 0;
  logic [3:0] btn = '0;
  logic [2:0] state;
  logic mode_disp, alarm_en, inc_pulse, dec_pulse;
  int total = 0, bad = 0, inc_cnt = 0, dec_cnt = 0;
  bit started = 0;
  int m_st = 0, m_idle = 0;
  bit m_md = 0, m_al = 0, m_inc = 0, m_dec = 0;
  bit [3:0] m_prev = 4'hF, m_pend = 4'h0;
  clock_mode_fsm #(.TIMEOUT_S(TO), .TO_W(2)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick),
    .btn_mode(btn[2]), .btn_up(btn[1]), .btn_down(btn[0]), .btn_set(btn[3]),
    .state(state), .mode_disp(mode_disp), .alarm_en(alarm_en),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    int old;
    if (reset) begin
      m_st = 0; m_idle = 0; m_md = 0; m_al = 0; m_inc = 0; m_dec = 0;
      m_prev = 4'hF; m_pend = 4'h0; started = 1;
    end else begin
      old = m_st;
      m_inc = 0; m_dec = 0;
      if (m_pend[3]) m_st = 0;
      else if (m_pend[2]) m_st = (m_st + 1) % 7;
      else if (m_pend[1] || m_pend[0]) begin
        if (m_st >= 1 && m_st <= 4) begin
          m_inc = m_pend[1];
          m_dec = !m_pend[1];
        end else if (m_st == 5) m_al = !m_al;
        else if (m_st == 6) m_md = !m_md;
      end
      if (m_st == 0 || m_st != old || m_pend != 0) m_idle = 0;
      else if (tick) begin
        m_idle++;
        if (m_idle == TO) begin
          m_st = 0;
          m_idle = 0;
        end
      end
      m_pend = btn & ~m_prev;
      m_prev = btn;
    end
    #2;
    if (started) begin
      check("model_state", int'(state), m_st);
      check("model_mode_disp", int'(mode_disp), int'(m_md));
      check("model_alarm_en", int'(alarm_en), int'(m_al));
      check("model_inc", int'(inc_pulse), int'(m_inc));
      check("model_dec", int'(dec_pulse), int'(m_dec));
    end
    if (inc_pulse) inc_cnt++;
    if (dec_pulse) dec_cnt++;
  end
  task automatic press(input int b);
    @(negedge clk) btn[b] = 1;
    repeat (2) @(negedge clk);
    btn[b] = 0;
    @(negedge clk);
  endtask
  task automatic tick_pulse();
    @(negedge clk) tick = 1;
    @(negedge clk) tick = 0;
  endtask
  initial begin
    int ic, dc;
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_state", int'(state), 0);
    check("rst_mode_disp", int'(mode_disp), 0);
    check("rst_alarm_en", int'(alarm_en), 0);
    check("rst_inc", int'(inc_pulse), 0);
    for (int i = 1; i <= 7; i++) begin
      press(2);
      check("mode_step", int'(state), i % 7);
    end
    repeat (6) press(2);
    check("to_set_fmt", int'(state), 6);
    ic = inc_cnt; dc = dec_cnt;
    press(1);
    check("fmt_up", int'(mode_disp), 1);
    press(0);
    check("fmt_down", int'(mode_disp), 0);
    check("fmt_no_inc", inc_cnt - ic, 0);
    check("fmt_no_dec", dec_cnt - dc, 0);
    repeat (3) press(2);
    check("to_set_min", int'(state), 2);
    ic = inc_cnt; dc = dec_cnt;
    repeat (3) press(1);
    press(0);
    check("min_inc_count", inc_cnt - ic, 3);
    check("min_dec_count", dec_cnt - dc, 1);
    press(2);
    check("to_al_hr", int'(state), 3);
    tick_pulse();
    tick_pulse();
    check("timeout_hold", int'(state), 3);
    tick_pulse();
    check("timeout_run", int'(state), 0);
    press(2);
    check("to_set_hr", int'(state), 1);
    ic = inc_cnt;
    @(negedge clk) btn = 4'b1010;
    repeat (2) @(negedge clk);
    btn = '0;
    @(negedge clk);
    check("set_beats_up", int'(state), 0);
    check("set_no_inc", inc_cnt - ic, 0);
    @(negedge clk) begin btn[2] = 1; reset = 1; end
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    check("held_mode_reset", int'(state), 0);
    btn[2] = 0;
    @(negedge clk);
    repeat (6) press(2);
    press(1);
    check("fmt_before_reset", int'(mode_disp), 1);
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    check("reset_mid_fmt_state", int'(state), 0);
    check("reset_mid_fmt_mode", int'(mode_disp), 0);
    repeat (4000) @(negedge clk) begin
      if ($urandom_range(31) == 0) btn[3] = ~btn[3];
      for (int b = 0; b < 3; b++) if ($urandom_range(11) == 0) btn[b] = ~btn[b];
      tick = ($urandom_range(2) == 0);
      reset = ($urandom_range(599) == 0);
    end
    @(negedge clk) begin btn = '0; tick = 0; reset = 0; end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
